// File: rtl/barrel_shifter_pkg.sv
// Shared types and constants for the barrel shifter/rotator.
package barrel_shifter_pkg;

  // Operation select; the reserved encoding behaves as a rotate.
  typedef enum logic [1:0] {
    MODE_ROT  = 2'b00,
    MODE_LSL  = 2'b01,
    MODE_ASR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Rotates wrap bits around; everything else fills vacated positions.
  function automatic logic is_rotate(input mode_e mode);
    return (mode == MODE_ROT) || (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One mux layer of the right-shift network: moves data right by DIST when enabled.
// Rotates wrap the low bits to the top; shifts fill the vacated top bits with fill_i.
module barrel_stage
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] wrapped;

  // Select between pass-through, wrapped rotate and filled shift.
  always_comb begin
    fill_mask = ~({WIDTH{1'b1}} >> DIST);
    shifted   = (data_i >> DIST) | (fill_i ? fill_mask : '0);
    wrapped   = (data_i >> DIST) | (data_i << (WIDTH - DIST));
    data_o    = data_i;
    if (en_i) begin
      data_o = is_rotate(mode_i) ? wrapped : shifted;
    end
  end

endmodule

// File: rtl/barrel_shifter.sv
// Single-cycle barrel shifter/rotator with registered result.
// Left operations reuse the right-shift network by bit-reversing its input and output.
// Optional: define BARREL_SHIFTER_ZERO_FLAG_EN to add a registered zero flag output.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   s,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  mode_e            op_mode;
  logic             fill;
  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] net_in;
  logic [WIDTH-1:0] net_out;
  logic [WIDTH-1:0] net_out_rev;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] stage_data [SHW+1];

  assign op_mode = mode_e'(mode);

  // Bit-reversal wrappers around the right-shift network.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign a_rev[i]       = A[WIDTH-1-i];
    assign net_out_rev[i] = net_out[WIDTH-1-i];
  end

  // Fill bit: sign only for arithmetic right; arithmetic left fills like logical left.
  always_comb begin
    fill = 1'b0;
    if (op_mode == MODE_ASR && dir == DIR_RIGHT) begin
      fill = A[WIDTH-1];
    end
  end

  // Route operand into the network, reversed for left operations.
  always_comb begin
    net_in = (dir == DIR_LEFT) ? a_rev : A;
  end

  assign stage_data[0] = net_in;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .DIST  (32'd1 << k)
    ) u_stage (
      .data_i (stage_data[k]),
      .en_i   (s[k]),
      .mode_i (op_mode),
      .fill_i (fill),
      .data_o (stage_data[k+1])
    );
  end

  assign net_out = stage_data[SHW];

  // Undo the reversal for left operations.
  always_comb begin
    y_d = (dir == DIR_LEFT) ? net_out_rev : net_out;
  end

  // Output register: result captured on accepted inputs, valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        y_q <= y_d;
      end
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag registered alongside y; resets high because y resets to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
    end else if (in_valid) begin
      zero_q <= (y_d == '0);
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed self-checking bench for barrel_shifter (4-bit default and an 8-bit instance).
module tb_barrel_shifter;

  logic       clk;
  logic       rst_n;
  logic [3:0] a4;
  logic [1:0] s4;
  logic       dir4;
  logic [1:0] mode4;
  logic       in_valid4;
  logic [3:0] y4;
  logic       out_valid4;
  logic [7:0] a8;
  logic [2:0] s8;
  logic       dir8;
  logic [1:0] mode8;
  logic       in_valid8;
  logic [7:0] y8;
  logic       out_valid8;
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
  logic       zero4;
  logic       zero8;
`endif

  int errors = 0;
  int checks = 0;

  barrel_shifter #(
    .WIDTH (4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a4),
    .s         (s4),
    .dir       (dir4),
    .mode      (mode4),
    .in_valid  (in_valid4),
    .y         (y4),
    .out_valid (out_valid4)
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    ,
    .zero      (zero4)
`endif
  );

  barrel_shifter #(
    .WIDTH (8)
  ) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a8),
    .s         (s8),
    .dir       (dir8),
    .mode      (mode8),
    .in_valid  (in_valid8),
    .y         (y8),
    .out_valid (out_valid8)
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    ,
    .zero      (zero8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Present one 4-bit operation and check the result one edge later.
  task automatic apply4(input string tag, input logic [3:0] a, input logic [1:0] sh,
                        input logic d, input logic [1:0] m, input logic [3:0] exp);
    @(negedge clk);
    a4        = a;
    s4        = sh;
    dir4      = d;
    mode4     = m;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    check(tag, {4'b0, y4}, {4'b0, exp});
    check({tag, "_valid"}, {7'b0, out_valid4}, 8'd1);
  endtask

  task automatic apply8(input string tag, input logic [7:0] a, input logic [2:0] sh,
                        input logic d, input logic [1:0] m, input logic [7:0] exp);
    @(negedge clk);
    a8        = a;
    s8        = sh;
    dir8      = d;
    mode8     = m;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    check(tag, y8, exp);
    check({tag, "_valid"}, {7'b0, out_valid8}, 8'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    a4        = '0;
    s4        = '0;
    dir4      = 1'b0;
    mode4     = 2'b00;
    in_valid4 = 1'b0;
    a8        = '0;
    s8        = '0;
    dir8      = 1'b0;
    mode8     = 2'b00;
    in_valid8 = 1'b0;

    #3;
    check("reset_y", {4'b0, y4}, 8'h00);
    check("reset_valid", {7'b0, out_valid4}, 8'd0);
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    check("reset_zero", {7'b0, zero4}, 8'd1);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero result, then assert reset mid-cycle.
    apply4("pre_reset", 4'b1010, 2'd1, 1'b0, 2'b00, 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_y", {4'b0, y4}, 8'h00);
    check("async_reset_valid", {7'b0, out_valid4}, 8'd0);
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    check("async_reset_zero", {7'b0, zero4}, 8'd1);
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid4 = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_y", {4'b0, y4}, 8'h00);
    check("post_reset_valid", {7'b0, out_valid4}, 8'd0);

    // Rotate right, back-to-back valid inputs.
    apply4("rotr_1010_1", 4'b1010, 2'd1, 1'b0, 2'b00, 4'b0101);
    apply4("rotr_1110_2", 4'b1110, 2'd2, 1'b0, 2'b00, 4'b1011);
    apply4("rotr_1000_3", 4'b1000, 2'd3, 1'b0, 2'b00, 4'b0001);
    apply4("rotr_0110_0", 4'b0110, 2'd0, 1'b0, 2'b00, 4'b0110);
    apply4("rotr_0111_1", 4'b0111, 2'd1, 1'b0, 2'b00, 4'b1011);
    apply4("rotr_0001_2", 4'b0001, 2'd2, 1'b0, 2'b00, 4'b0100);
    apply4("rotr_0101_3", 4'b0101, 2'd3, 1'b0, 2'b00, 4'b1010);

    // Rotate left.
    apply4("rotl_1000_1", 4'b1000, 2'd1, 1'b1, 2'b00, 4'b0001);
    apply4("rotl_0110_3", 4'b0110, 2'd3, 1'b1, 2'b00, 4'b0011);

    // Logical and arithmetic shifts.
    apply4("lsr_1110_2", 4'b1110, 2'd2, 1'b0, 2'b01, 4'b0011);
    apply4("lsl_1110_2", 4'b1110, 2'd2, 1'b1, 2'b01, 4'b1000);
    apply4("asr_1000_2", 4'b1000, 2'd2, 1'b0, 2'b10, 4'b1110);
    apply4("asr_0100_1", 4'b0100, 2'd1, 1'b0, 2'b10, 4'b0010);
    apply4("asl_1011_1", 4'b1011, 2'd1, 1'b1, 2'b10, 4'b0110);
    apply4("lsr_1011_3", 4'b1011, 2'd3, 1'b0, 2'b01, 4'b0001);
    apply4("lsl_1011_0", 4'b1011, 2'd0, 1'b1, 2'b01, 4'b1011);
    apply4("asr_1001_0", 4'b1001, 2'd0, 1'b0, 2'b10, 4'b1001);
    apply4("rsvd_1100_1", 4'b1100, 2'd1, 1'b0, 2'b11, 4'b0110);
    apply4("rsvd_l_1100_1", 4'b1100, 2'd1, 1'b1, 2'b11, 4'b1001);
    apply4("lsr_0001_1", 4'b0001, 2'd1, 1'b0, 2'b01, 4'b0000);
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    check("zero_set", {7'b0, zero4}, 8'd1);
`endif

    // Hold: y keeps its value while in_valid is low even as inputs change.
    apply4("hold_load", 4'b1010, 2'd1, 1'b0, 2'b00, 4'b0101);
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    check("zero_clear", {7'b0, zero4}, 8'd0);
`endif
    @(negedge clk);
    in_valid4 = 1'b0;
    a4        = 4'b1111;
    s4        = 2'd3;
    mode4     = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_y_%0d", i), {4'b0, y4}, 8'b0000_0101);
      check($sformatf("hold_valid_%0d", i), {7'b0, out_valid4}, 8'd0);
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
      check($sformatf("hold_zero_%0d", i), {7'b0, zero4}, 8'd0);
`endif
    end

    // 8-bit instance.
    apply8("w8_rotr_5", 8'b1001_0110, 3'd5, 1'b0, 2'b00, 8'b1011_0100);
    apply8("w8_rsvd_5", 8'b1001_0110, 3'd5, 1'b0, 2'b11, 8'b1011_0100);
    apply8("w8_asr_3", 8'b1001_0110, 3'd3, 1'b0, 2'b10, 8'b1111_0010);
    apply8("w8_lsl_7", 8'b1001_0111, 3'd7, 1'b1, 2'b01, 8'b1000_0000);
    apply8("w8_lsr_7", 8'b1001_0110, 3'd7, 1'b0, 2'b01, 8'b0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
